// File: rtl/hazard_scoreboard_if.sv
// ID-stage operand/destination fields into the hazard scoreboard and the
// stall, bubble, forwarding and counter results back to the pipeline.
interface hazard_scoreboard_if #(
    parameter int CNT_W = 32
);
    logic             ID_Valid;
    logic             R1_Used;
    logic             R2_Used;
    logic [4:0]       ID_Rs1;
    logic [4:0]       ID_Rs2;
    logic [4:0]       ID_Rd;
    logic             ID_RegWrite;
    logic             ID_MemRead;
    logic             Flush;
    logic             Freeze;
    logic             Stall;
    logic             Bubble;
    logic [1:0]       Fwd1_Sel;
    logic [1:0]       Fwd2_Sel;
    logic [CNT_W-1:0] Stall_Count;

    modport master (
        output ID_Valid, R1_Used, R2_Used, ID_Rs1, ID_Rs2, ID_Rd,
               ID_RegWrite, ID_MemRead, Flush, Freeze,
        input  Stall, Bubble, Fwd1_Sel, Fwd2_Sel, Stall_Count
    );

    modport slave (
        input  ID_Valid, R1_Used, R2_Used, ID_Rs1, ID_Rs2, ID_Rd,
               ID_RegWrite, ID_MemRead, Flush, Freeze,
        output Stall, Bubble, Fwd1_Sel, Fwd2_Sel, Stall_Count
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks EX/MEM/WB destination registers for the 5-stage pipeline and derives
// load-use stalls, registered EX forwarding selects and a load-use bubble count.
module hazard_scoreboard #(
    parameter int CNT_W = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    hazard_scoreboard_if.slave bus
);

    logic             r_ex_v,  r_mem_v,  r_wb_v;
    logic [4:0]       r_ex_rd, r_mem_rd, r_wb_rd;
    logic             r_ex_rw, r_mem_rw, r_wb_rw;
    logic             r_ex_ld, r_mem_ld, r_wb_ld;
    logic [1:0]       r_fwd1,  r_fwd2;
    logic [CNT_W-1:0] r_cnt;

    logic             w_ex_wr, w_mem_wr;
    logic             w_hazard, w_bubble, w_kill;
    logic [1:0]       w_fwd1, w_fwd2;
    logic             w_unused;

    function automatic logic [1:0] fwd_sel(
        input logic       used,
        input logic [4:0] rs,
        input logic       ex_wr,
        input logic       ex_ld,
        input logic [4:0] ex_rd,
        input logic       mem_wr,
        input logic [4:0] mem_rd
    );
        // A load in EX cannot forward; its consumer is bubbled instead.
        if (used && ex_wr && (rs == ex_rd) && !ex_ld)
            return 2'd1;
        else if (used && mem_wr && (rs == mem_rd))
            return 2'd2;
        else
            return 2'd0;
    endfunction

    assign w_ex_wr  = r_ex_v  & r_ex_rw  & (r_ex_rd  != 5'd0);
    assign w_mem_wr = r_mem_v & r_mem_rw & (r_mem_rd != 5'd0);

    assign w_hazard = bus.ID_Valid & w_ex_wr & r_ex_ld &
                      ((bus.R1_Used & (bus.ID_Rs1 == r_ex_rd)) |
                       (bus.R2_Used & (bus.ID_Rs2 == r_ex_rd)));
    assign w_bubble = w_hazard & ~bus.Flush & ~bus.Freeze;
    assign w_kill   = w_bubble | bus.Flush;

    assign w_fwd1 = fwd_sel(bus.R1_Used, bus.ID_Rs1, w_ex_wr, r_ex_ld, r_ex_rd,
                            w_mem_wr, r_mem_rd);
    assign w_fwd2 = fwd_sel(bus.R2_Used, bus.ID_Rs2, w_ex_wr, r_ex_ld, r_ex_rd,
                            w_mem_wr, r_mem_rd);

    // Valids, selects and counter: cleared by reset, frozen by Freeze.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_ex_v  <= 1'b0;
            r_mem_v <= 1'b0;
            r_wb_v  <= 1'b0;
            r_fwd1  <= 2'd0;
            r_fwd2  <= 2'd0;
            r_cnt   <= '0;
        end else if (!bus.Freeze) begin
            r_ex_v  <= bus.ID_Valid & ~w_kill;
            // Flush also kills the instruction currently in EX.
            r_mem_v <= r_ex_v & ~bus.Flush;
            r_wb_v  <= r_mem_v;
            r_fwd1  <= w_kill ? 2'd0 : w_fwd1;
            r_fwd2  <= w_kill ? 2'd0 : w_fwd2;
            r_cnt   <= r_cnt + CNT_W'(w_bubble);
        end
    end

    // Entry payloads are qualified by the valids, so they need no reset.
    always_ff @(posedge CLK) begin
        if (!bus.Freeze) begin
            r_ex_rd  <= bus.ID_Rd;
            r_ex_rw  <= bus.ID_RegWrite;
            r_ex_ld  <= bus.ID_MemRead;
            r_mem_rd <= r_ex_rd;
            r_mem_rw <= r_ex_rw;
            r_mem_ld <= r_ex_ld;
            r_wb_rd  <= r_mem_rd;
            r_wb_rw  <= r_mem_rw;
            r_wb_ld  <= r_mem_ld;
        end
    end

    assign w_unused = ^{r_wb_v, r_wb_rd, r_wb_rw, r_wb_ld, r_mem_ld};

    assign bus.Stall       = w_bubble;
    assign bus.Bubble      = w_bubble;
    assign bus.Fwd1_Sel    = r_fwd1;
    assign bus.Fwd2_Sel    = r_fwd2;
    assign bus.Stall_Count = r_cnt;

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Hazard scoreboard for the interrupt-capable 5-stage pipeline; it sits directly downstream of the ID-stage operand-usage decoder and consumes its R1_Used/R2_Used flags together with the ID-stage register fields. It tracks destination registers of instructions in EX, MEM and WB in an internal shift register. From that state it generates load-use stalls/bubbles, registered forwarding selects for the instruction entering EX, and a load-use stall counter.

## Interface
- CNT_W, 32, width of load-use stall counter
- CLK  input  1  pipeline clock, rising edge
- RST_N  input  1  asynchronous active-low reset
- ID_Valid  input  1  ID stage holds a live instruction
- R1_Used  input  1  ID instruction reads rs1 (from operand-usage decoder)
- R2_Used  input  1  ID instruction reads rs2
- ID_Rs1, ID_Rs2  input  5 each  source register numbers in ID
- ID_Rd  input  5  destination register in ID
- ID_RegWrite  input  1  ID instruction writes ID_Rd
- ID_MemRead  input  1  ID instruction is a load (lb/lh/lw/lbu/lhu)
- Flush  input  1  branch taken / jump / interrupt entry / uret: kill ID and EX
- Freeze  input  1  global pipeline hold (memory busy, halt)
- Stall  output  1  hold PC and IF/ID (combinational)
- Bubble  output  1  load NOP into ID/EX (combinational)
- Fwd1_Sel, Fwd2_Sel  output  2 each  registered EX operand select: 0 regfile, 1 MEM-stage ALU result, 2 WB-stage write data
- Stall_Count  output  CNT_W  number of load-use bubbles inserted

## Operation
- Entries EX, MEM, WB each hold {V, Rd, RW, LD}; entry "writes" iff V & RW & Rd != 0. x0 never matches.
- Load-use hazard: ID_Valid & EX writes & EX.LD & ((R1_Used & ID_Rs1==EX.Rd) | (R2_Used & ID_Rs2==EX.Rd)). Unused operands never cause a stall.
- Stall = Bubble = hazard & !Flush & !Freeze.
- Advance (when !Freeze): WB<=MEM, MEM<=EX; EX<=ID fields with V=ID_Valid, unless Bubble or Flush, then EX.V<=0.
- Freeze: all entries, Fwd selects and Stall_Count hold; Stall=Bubble=0; Freeze dominates Flush.
- Flush (no Freeze): EX.V forced 0 on the advance, so the killed EX instruction is dropped from MEM next cycle; current MEM/WB advance normally; Fwd selects <=0.
- Forward select per operand, computed in ID and registered on advance: if used & EX writes & Rs==EX.Rd & !EX.LD -> 1; else if used & MEM writes & Rs==MEM.Rd -> 2; else 0. EX match has priority over MEM. Registered value is 0 on Bubble or Flush.
- Stall_Count increments by 1 on every cycle Bubble=1; wraps modulo 2^CNT_W.

## Timing
- Reset: all V=0, Fwd1_Sel=Fwd2_Sel=0, Stall_Count=0; hence Stall=Bubble=0. Reset asserted mid-operation discards all entries immediately.
- Stall/Bubble: zero latency from ID inputs and EX entry.
- Fwd selects: valid one cycle after the instruction's ID cycle, i.e. during its EX cycle.
- Load-use: exactly one bubble; on the following cycle the load is in MEM, hazard clears, dependent enters EX with Fwd=2.
- Back-to-back same Rd writes: youngest (EX) wins.
- Flush and hazard same cycle: no stall, no count.

## Test plan
- ADD x5 then ADD x6,x5,x1 -> no stall; second instr in EX with Fwd1_Sel=1, Fwd2_Sel=0.
- LW x5 then ADD x6,x5,x5 -> Stall=Bubble=1 one cycle, Stall_Count 0->1; next cycle EX has Fwd1_Sel=Fwd2_Sel=2.
- LW x5 then ADDI x7,x0,5 / SW with rs2=x5 and R1_Used only on x5? -> LW x5 then LUI-like (R1_Used=0, Rs1=5) -> no stall, Fwd=0.
- LW x0 then ADD x1,x0,x0 -> no stall, Fwd=0 (x0 rule).
- LW x5, dependent in ID, Flush=1 same cycle -> Stall=0, count unchanged, EX invalid next cycle; Freeze=1 for 3 cycles mid-hazard -> all outputs hold, count unchanged.
- Stall_Count preset near 2^CNT_W-1 via repeated load-use (CNT_W=4): 16 bubbles -> counter wraps to 0; RST_N low mid-stream -> all outputs 0 asynchronously.
